// File: rtl/gba_keypad_if.sv
// Keypad signal bundle between the platform/IO register file (master) and gba_keypad (slave).
interface gba_keypad_if;
    logic [9:0]  buttons_raw;
    logic [15:0] keycnt;
    logic [15:0] keyinput;
    logic [9:0]  key_state;
    logic        keypad_irq;

    modport master (
        output buttons_raw,
        output keycnt,
        input  keyinput,
        input  key_state,
        input  keypad_irq
    );

    modport slave (
        input  buttons_raw,
        input  keycnt,
        output keyinput,
        output key_state,
        output keypad_irq
    );
endinterface

// File: rtl/gba_keypad.sv
// GBA keypad front end: per-key synchroniser and debounce, KEYINPUT generation,
// and the KEYCNT-driven keypad interrupt as a single-cycle pulse.
module gba_keypad #(
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int CNT_W           = 16
) (
    input logic         gba_clk,
    input logic         reset,
    gba_keypad_if.slave kp
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]       s1;
    logic [9:0]       s2;
    logic [9:0]       key_state;
    logic [CNT_W-1:0] cnt [10];
    logic [9:0]       mask;
    logic [9:0]       hit;
    logic             cond;
    logic             active;
    logic             cond_q;
    logic             irq;
    logic             unused_keycnt;

    always_ff @(posedge gba_clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= kp.buttons_raw;
            s2 <= s1;
        end
    end

    // A key only changes after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge gba_clk or posedge reset) begin
        if (reset) begin
            key_state <= '0;
            for (int i = 0; i < 10; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (s2[i] == key_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    key_state[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mask = kp.keycnt[9:0];
        hit  = key_state & mask;
        cond = 1'b0;
        if (kp.keycnt[15]) begin
            cond = (mask != '0) && (hit == mask);
        end else begin
            cond = |hit;
        end
        active = cond & kp.keycnt[14];
    end

    // Pulse only on the rising edge of the enabled condition, so a held combination fires once.
    always_ff @(posedge gba_clk or posedge reset) begin
        if (reset) begin
            cond_q <= 1'b0;
            irq    <= 1'b0;
        end else begin
            cond_q <= active;
            irq    <= active & ~cond_q;
        end
    end

    assign unused_keycnt = ^kp.keycnt[13:10];

    assign kp.key_state  = key_state;
    assign kp.keyinput   = {6'b0, ~key_state};
    assign kp.keypad_irq = irq;
endmodule

// File: tb/tb_gba_keypad.sv
// Self-checking bench for gba_keypad: directed scenarios plus random key/KEYCNT traffic
// compared every cycle against a sample-history reference model.
module tb_gba_keypad;
    localparam int DB = 4;

    logic gba_clk = 1'b0;
    logic reset   = 1'b1;

    gba_keypad_if kp ();

    gba_keypad #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (16)
    ) dut (
        .gba_clk (gba_clk),
        .reset   (reset),
        .kp      (kp)
    );

    always #5 gba_clk = ~gba_clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int irq_count    = 0;

    logic [9:0] m_state;
    logic       m_irq;
    logic       m_prev_active;
    logic [9:0] samp_q [$];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Interrupt condition from KEYCNT: OR of selected keys, or all selected keys in AND mode.
    function automatic logic model_cond(input logic [9:0] st, input logic [15:0] kc);
        int sel     = 0;
        int pressed = 0;
        for (int i = 0; i < 10; i++) begin
            if (kc[i]) begin
                sel++;
                if (st[i]) pressed++;
            end
        end
        if (kc[15]) return (sel > 0) && (pressed == sel);
        return pressed > 0;
    endfunction

    task automatic reset_model();
        m_state       = '0;
        m_irq         = 1'b0;
        m_prev_active = 1'b0;
        samp_q.delete();
        for (int k = 0; k < DB + 2; k++) samp_q.push_back(10'h000);
    endtask

    // A key flips once the last DB synchronised samples (raw delayed two edges) all disagree with it.
    task automatic step_model();
        logic       act;
        logic [9:0] nxt;
        bit         all_diff;
        act           = kp.keycnt[14] & model_cond(m_state, kp.keycnt);
        m_irq         = act & ~m_prev_active;
        m_prev_active = act;
        samp_q.push_front(kp.buttons_raw);
        void'(samp_q.pop_back());
        nxt = m_state;
        for (int i = 0; i < 10; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= DB + 1; k++) begin
                if (samp_q[k][i] == m_state[i]) all_diff = 1'b0;
            end
            if (all_diff) nxt[i] = ~m_state[i];
        end
        m_state = nxt;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge gba_clk or posedge reset);
            if (reset) reset_model();
            else       step_model();
        end
    end

    initial begin
        forever begin
            @(posedge gba_clk);
            #3;
            checkOutput("key_state", 16'(kp.key_state), 16'(m_state));
            checkOutput("keyinput", kp.keyinput, {6'b0, ~m_state});
            checkOutput("keypad_irq", 16'(kp.keypad_irq), 16'(m_irq));
            if (kp.keypad_irq) irq_count++;
        end
    end

    task automatic applyStimulus(input logic [9:0] raw, input logic [15:0] kc);
        @(negedge gba_clk);
        kp.buttons_raw = raw;
        kp.keycnt      = kc;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge gba_clk);
        #4;
    endtask

    initial begin
        int         base;
        logic [9:0] raw;
        logic [15:0] kc;
        logic [15:0] exp_ki;

        kp.buttons_raw = '0;
        kp.keycnt      = '0;
        wait_edges(2);
        checkOutput("rst_keyinput", kp.keyinput, 16'h03FF);
        checkOutput("rst_irq", 16'(kp.keypad_irq), 16'h0000);
        @(negedge gba_clk);
        reset = 1'b0;
        wait_edges(4);
        checkOutput("idle_keyinput", kp.keyinput, 16'h03FF);
        checkOutput("idle_key_state", 16'(kp.key_state), 16'h0000);

        $display("[TB] press A with OR mask A");
        applyStimulus(10'h001, 16'h4001);
        wait_edges(5);
        checkOutput("a_early_state", 16'(kp.key_state), 16'h0000);
        checkOutput("a_early_keyinput", kp.keyinput, 16'h03FF);
        wait_edges(1);
        checkOutput("a_set_state", 16'(kp.key_state), 16'h0001);
        checkOutput("a_set_keyinput", kp.keyinput, 16'h03FE);
        checkOutput("a_set_irq", 16'(kp.keypad_irq), 16'h0000);
        wait_edges(1);
        checkOutput("a_irq_pulse", 16'(kp.keypad_irq), 16'h0001);
        wait_edges(1);
        checkOutput("a_irq_drop", 16'(kp.keypad_irq), 16'h0000);
        base = irq_count;
        wait_edges(100);
        checkOutput("a_hold_pulses", 16'(irq_count - base), 16'h0000);

        base = irq_count;
        applyStimulus(10'h000, 16'h4001);
        wait_edges(10);
        applyStimulus(10'h001, 16'h4001);
        wait_edges(10);
        checkOutput("a_repress_pulses", 16'(irq_count - base), 16'h0001);

        $display("[TB] short glitch on Start");
        applyStimulus(10'h000, 16'h0001);
        wait_edges(10);
        applyStimulus(10'h008, 16'h0001);
        applyStimulus(10'h008, 16'h0001);
        applyStimulus(10'h008, 16'h0001);
        applyStimulus(10'h000, 16'h0001);
        wait_edges(10);
        checkOutput("glitch_state", 16'(kp.key_state), 16'h0000);
        checkOutput("glitch_keyinput", kp.keyinput, 16'h03FF);

        $display("[TB] AND mode");
        applyStimulus(10'h000, 16'hC003);
        wait_edges(10);
        base = irq_count;
        applyStimulus(10'h001, 16'hC003);
        wait_edges(10);
        checkOutput("and_a_only", 16'(irq_count - base), 16'h0000);
        base = irq_count;
        applyStimulus(10'h003, 16'hC003);
        wait_edges(10);
        checkOutput("and_a_b", 16'(irq_count - base), 16'h0001);
        base = irq_count;
        applyStimulus(10'h3FF, 16'hC000);
        wait_edges(12);
        checkOutput("and_empty_mask", 16'(irq_count - base), 16'h0000);

        $display("[TB] enable while condition true");
        applyStimulus(10'h001, 16'h0001);
        wait_edges(12);
        checkOutput("hold_a_state", 16'(kp.key_state), 16'h0001);
        applyStimulus(10'h001, 16'h4001);
        wait_edges(1);
        checkOutput("enable_pulse", 16'(kp.keypad_irq), 16'h0001);
        wait_edges(1);
        checkOutput("enable_drop", 16'(kp.keypad_irq), 16'h0000);

        $display("[TB] reset during debounce of B");
        applyStimulus(10'h003, 16'h4001);
        wait_edges(3);
        @(negedge gba_clk);
        reset = 1'b1;
        wait_edges(2);
        checkOutput("mid_rst_state", 16'(kp.key_state), 16'h0000);
        @(negedge gba_clk);
        reset = 1'b0;
        wait_edges(5);
        checkOutput("post_rst_early", 16'(kp.key_state), 16'h0000);
        wait_edges(1);
        checkOutput("post_rst_state", 16'(kp.key_state), 16'h0003);
        checkOutput("post_rst_noirq", 16'(kp.keypad_irq), 16'h0000);
        wait_edges(1);
        checkOutput("post_rst_irq", 16'(kp.keypad_irq), 16'h0001);

        $display("[TB] bit sweep");
        for (int b = 0; b < 10; b++) begin
            applyStimulus(10'(1 << b), 16'h0000);
            wait_edges(8);
            exp_ki    = 16'h03FF;
            exp_ki[b] = 1'b0;
            checkOutput("sweep_keyinput", kp.keyinput, exp_ki);
        end

        $display("[TB] random traffic");
        raw = '0;
        kc  = 16'h4001;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
            end
            if ($urandom_range(0, 19) == 0) begin
                kc        = 16'($urandom);
                kc[14]    = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(raw, kc);
            if ($urandom_range(0, 499) == 0) begin
                @(negedge gba_clk);
                reset = 1'b1;
                @(negedge gba_clk);
                reset = 1'b0;
            end
        end

        wait_edges(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
